link_training_ctrl: RTL
=======================

# link_training_ctrl

Sequencer for the link training path. It runs the local preamble generator to train the peer, then arms the preamble detector to measure the peer's bit period. It validates the measured clock divider and drives link-up or link-fail status to the serializer/deserializer and FEC datapath. Measurement failures and timeouts are retried up to a configurable limit.

## Interface
- DIV_WIDTH, 8, width of clock-divider values (matches generator/detector)
- TO_WIDTH, 16, width of the detect timeout counter
- MAX_RETRIES, 3, retrain attempts after the first before declaring failure (1..15)
- DIV_MIN, 2, smallest accepted measured divider (inclusive)
- DIV_MAX, 200, largest accepted measured divider (inclusive)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- link_start  in  1  one-cycle request to (re)train
- cfg_timeout  in  TO_WIDTH  max cycles to wait for detector done; 0 disables the timeout
- pre_start  out  1  one-cycle start to the preamble generator
- pre_done  in  1  one-cycle done from the generator
- det_start  out  1  one-cycle start to the preamble detector
- det_enable  out  1  detector count enable
- det_done  in  1  one-cycle done from the detector
- det_clk_div  in  DIV_WIDTH  detector divider output, valid the cycle after det_done
- rx_clk_div  out  DIV_WIDTH  latched accepted divider
- link_up  out  1  training succeeded; rx_clk_div valid
- link_fail  out  1  retries exhausted
- busy  out  1  high in every state except IDLE, UP, FAIL
- retry_cnt  out  4  retries consumed in the current attempt sequence

## Operation
- States: IDLE, TX_START, TX_WAIT, RX_START, RX_WAIT, RX_CAP, CHECK, UP, FAIL.
- IDLE/UP/FAIL + link_start → TX_START.
  - link_start entry clears retry_cnt, link_up, link_fail and rx_clk_div.
  - link_start in any other state is ignored.
- TX_START: pre_start=1 for this cycle only → TX_WAIT.
- TX_WAIT: wait for pre_done → RX_START. There is no timeout here; the generator always completes.
- RX_START: det_start=1 for one cycle and timeout counter cleared → RX_WAIT.
- det_enable=1 in RX_START, RX_WAIT and RX_CAP only.
- RX_WAIT:
  - det_done → RX_CAP.
  - Else, if cfg_timeout≠0 and counter==cfg_timeout-1 → retry path.
  - Else counter increments.
  - det_done has priority over timeout in the same cycle.
- RX_CAP: sample det_clk_div into a holding register → CHECK.
- CHECK:
  - DIV_MIN ≤ held value ≤ DIV_MAX → copy to rx_clk_div → UP.
  - Otherwise → retry path.
- Retry path:
  - retry_cnt < MAX_RETRIES → retry_cnt+1 → TX_START (full re-send of the preamble).
  - Otherwise → FAIL.
- UP: link_up=1, held until next link_start or reset.
- FAIL: link_fail=1, held until next link_start or reset.
- Comparisons are unsigned and DIV_WIDTH bits. The timeout counter is TO_WIDTH bits and never wraps (bounded by cfg_timeout). cfg_timeout is sampled live.
- Reset mid-operation returns to IDLE immediately. The generator and detector share rst_n and reset themselves.

## Timing
- Reset values: all outputs 0, state IDLE.
- All outputs are registered except busy, which is decoded from state.
- pre_start asserts the cycle after link_start is sampled.
- det_start asserts the cycle after pre_done is sampled.
- From det_done high at cycle N:
  - RX_CAP occurs at N+1 and samples det_clk_div.
  - CHECK occurs at N+2.
  - link_up rises at N+3.
- Timeout: with cfg_timeout=T, det_start at cycle S and no det_done, pre_start re-asserts at S+T+2.
- Minimum turnaround between successive attempts: 1 cycle of TX_START.
- link_start and det_done in the same cycle in RX_WAIT: det_done wins; link_start is dropped.

## Test plan
- Nominal run:
  - Stimulus: generator model asserts pre_done 20 cycles after pre_start; detector model asserts det_done, then det_clk_div=10 the following cycle.
  - Response: exactly one pre_start and one det_start; link_up=1 three cycles after det_done; rx_clk_div=10; retry_cnt=0; busy=0.
- Timeout retry:
  - Stimulus: cfg_timeout=50; detector silent on the first attempt, det_clk_div=12 on the second.
  - Response: second pre_start at det_start+52; retry_cnt=1; link_up=1; rx_clk_div=12.
- Range rejection:
  - Stimulus: det_clk_div=1, then 201, then 200.
  - Response: two retries; link_up with rx_clk_div=200; retry_cnt=2.
- Exhaustion:
  - Stimulus: MAX_RETRIES=3; detector never responds, cfg_timeout=8.
  - Response: four pre_start pulses total; link_fail=1, retry_cnt=3; then a link_start clears link_fail and begins TX_START.
- cfg_timeout=0:
  - Stimulus: det_done arrives after 100000 cycles.
  - Response: no retry; link_up asserted.
- Reset and ignored requests:
  - Stimulus: rst_n low during RX_WAIT.
  - Response: all outputs 0 that cycle, state IDLE.
  - Stimulus: link_start during TX_WAIT.
  - Response: ignored; no extra pre_start.

Source files
------------

// File: rtl/link_training_ctrl.sv
// Link training sequencer: trains the peer with the preamble generator, measures
// the peer bit period with the detector, validates the divider and retries on failure.
module link_training_ctrl #(
  parameter int DIV_WIDTH   = 8,
  parameter int TO_WIDTH    = 16,
  parameter int MAX_RETRIES = 3,
  parameter int DIV_MIN     = 2,
  parameter int DIV_MAX     = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_link_start,
  input  logic [TO_WIDTH-1:0]  i_cfg_timeout,
  output logic                 o_pre_start,
  input  logic                 i_pre_done,
  output logic                 o_det_start,
  output logic                 o_det_enable,
  input  logic                 i_det_done,
  input  logic [DIV_WIDTH-1:0] i_det_clk_div,
  output logic [DIV_WIDTH-1:0] o_rx_clk_div,
  output logic                 o_link_up,
  output logic                 o_link_fail,
  output logic                 o_busy,
  output logic [3:0]           o_retry_cnt
);

  // state    | meaning
  // IDLE     | waiting for link_start after reset
  // TX_START | one-cycle start pulse to the preamble generator
  // TX_WAIT  | waiting for the generator to finish
  // RX_START | one-cycle start pulse to the detector, timeout counter cleared
  // RX_WAIT  | waiting for the detector, timeout running
  // RX_CAP   | capture the measured divider
  // CHECK    | range-check the captured divider
  // UP       | link trained, rx_clk_div valid
  // FAIL     | retries exhausted
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TX_START = 4'd1,
    S_TX_WAIT  = 4'd2,
    S_RX_START = 4'd3,
    S_RX_WAIT  = 4'd4,
    S_RX_CAP   = 4'd5,
    S_CHECK    = 4'd6,
    S_UP       = 4'd7,
    S_FAIL     = 4'd8
  } state_t;

  localparam logic [DIV_WIDTH-1:0] LP_DIV_MIN     = DIV_WIDTH'(DIV_MIN);
  localparam logic [DIV_WIDTH-1:0] LP_DIV_MAX     = DIV_WIDTH'(DIV_MAX);
  localparam logic [3:0]           LP_MAX_RETRIES = 4'(MAX_RETRIES);
  localparam logic [TO_WIDTH-1:0]  LP_TO_ONE      = TO_WIDTH'(1);

  state_t               r_state;
  state_t               w_next;
  logic [TO_WIDTH-1:0]  r_to_cnt;
  logic [TO_WIDTH-1:0]  w_to_cnt_nxt;
  logic                 r_to_hit;
  logic                 w_to_hit;
  logic                 w_to_expired;
  logic                 w_retry;
  logic                 w_div_ok;
  logic [3:0]           r_retry_cnt;
  logic [3:0]           w_retry_nxt;
  logic [DIV_WIDTH-1:0] r_div_hold;
  logic [DIV_WIDTH-1:0] r_rx_clk_div;
  logic [DIV_WIDTH-1:0] w_rx_div_nxt;
  logic                 r_pre_start;
  logic                 r_det_start;
  logic                 r_det_enable;
  logic                 r_link_up;
  logic                 r_link_fail;

  // >= rather than == keeps the timeout alive if cfg_timeout is lowered mid-wait
  assign w_to_expired = (i_cfg_timeout != '0) && (r_to_cnt >= (i_cfg_timeout - LP_TO_ONE));
  assign w_div_ok     = (r_div_hold >= LP_DIV_MIN) && (r_div_hold <= LP_DIV_MAX);

  always_comb begin
    w_next       = r_state;
    w_retry      = 1'b0;
    w_to_hit     = 1'b0;
    w_to_cnt_nxt = r_to_cnt;
    w_retry_nxt  = r_retry_cnt;
    w_rx_div_nxt = r_rx_clk_div;
    case (r_state)
      S_IDLE, S_UP, S_FAIL: begin
        if (i_link_start) begin
          w_next       = S_TX_START;
          w_retry_nxt  = '0;
          w_rx_div_nxt = '0;
        end
      end
      S_TX_START: w_next = S_TX_WAIT;
      S_TX_WAIT: begin
        if (i_pre_done) w_next = S_RX_START;
      end
      S_RX_START: begin
        w_to_cnt_nxt = '0;
        w_next       = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        // expiry is registered for one cycle before the retry is taken
        if (i_det_done)             w_next = S_RX_CAP;
        else if (r_to_hit)          w_retry = 1'b1;
        else if (w_to_expired)      w_to_hit = 1'b1;
        else if (r_to_cnt != '1)    w_to_cnt_nxt = r_to_cnt + LP_TO_ONE;
      end
      S_RX_CAP: w_next = S_CHECK;
      S_CHECK: begin
        if (w_div_ok) begin
          w_rx_div_nxt = r_div_hold;
          w_next       = S_UP;
        end else begin
          w_retry = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_retry) begin
      if (r_retry_cnt < LP_MAX_RETRIES) begin
        w_retry_nxt = r_retry_cnt + 4'd1;
        w_next      = S_TX_START;
      end else begin
        w_next = S_FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_to_cnt     <= '0;
      r_to_hit     <= 1'b0;
      r_retry_cnt  <= '0;
      r_div_hold   <= '0;
      r_rx_clk_div <= '0;
      r_pre_start  <= 1'b0;
      r_det_start  <= 1'b0;
      r_det_enable <= 1'b0;
      r_link_up    <= 1'b0;
      r_link_fail  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_to_cnt     <= w_to_cnt_nxt;
      r_to_hit     <= w_to_hit;
      r_retry_cnt  <= w_retry_nxt;
      r_rx_clk_div <= w_rx_div_nxt;
      if (r_state == S_RX_CAP) r_div_hold <= i_det_clk_div;
      // outputs decoded from the next state so they line up with the state itself
      r_pre_start  <= (w_next == S_TX_START);
      r_det_start  <= (w_next == S_RX_START);
      r_det_enable <= (w_next == S_RX_START) || (w_next == S_RX_WAIT) || (w_next == S_RX_CAP);
      r_link_up    <= (w_next == S_UP);
      r_link_fail  <= (w_next == S_FAIL);
    end
  end

  assign o_busy       = !((r_state == S_IDLE) || (r_state == S_UP) || (r_state == S_FAIL));
  assign o_pre_start  = r_pre_start;
  assign o_det_start  = r_det_start;
  assign o_det_enable = r_det_enable;
  assign o_rx_clk_div = r_rx_clk_div;
  assign o_link_up    = r_link_up;
  assign o_link_fail  = r_link_fail;
  assign o_retry_cnt  = r_retry_cnt;

endmodule
